fp_addsub_pipe: RTL and testbench

//  Parametrised, pipelined IEEE-754 add/subtract unit for the rv32imf execute stage; successor to the fixed FP32 adder.

---
 rtl/fp_addsub_pipe_pkg.sv | 38 +++
 rtl/fp_addsub_pipe_if.sv | 31 +++
 rtl/fp_lzc.sv | 16 +
 rtl/fp_addsub_pipe.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp_addsub_pipe_pkg.sv
// Shared types for the pipelined FP add/sub unit: rounding modes, exception flags
// and the mapping from the raw rm field to a rounding mode.
package fp_addsub_pipe_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  localparam logic [4:0] FFLAG_NV = 5'b10000;
  localparam logic [4:0] FFLAG_DZ = 5'b01000;
  localparam logic [4:0] FFLAG_OF = 5'b00100;
  localparam logic [4:0] FFLAG_UF = 5'b00010;
  localparam logic [4:0] FFLAG_NX = 5'b00001;

  // Reserved encodings fall back to round-to-nearest-even.
  function automatic rm_e decode_rm(input logic [2:0] raw);
    case (raw)
      3'b001:  return RM_RTZ;
      3'b010:  return RM_RDN;
      3'b011:  return RM_RUP;
      3'b100:  return RM_RMM;
      default: return RM_RNE;
    endcase
  endfunction

endpackage

// File: rtl/fp_addsub_pipe_if.sv
// Operation bus of the FP add/sub pipe: operands and tag in, rounded result out.
interface fp_addsub_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 32
);
    localparam int W = 1 + EXP_W + MAN_W;

    // valid_i qualifies an operation only on an edge where en=1; there is no ready,
    // the whole pipe stalls through en. valid_o qualifies result/fflags/tag_o.
    logic             valid_i;
    logic             add_sub;
    logic [W-1:0]     num1;
    logic [W-1:0]     num2;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag_i;
    logic             valid_o;
    logic [W-1:0]     result;
    logic [4:0]       fflags;
    logic [TAG_W-1:0] tag_o;

    modport master (
        output valid_i, add_sub, num1, num2, rm, tag_i,
        input  valid_o, result, fflags, tag_o
    );

    modport slave (
        input  valid_i, add_sub, num1, num2, rm, tag_i,
        output valid_o, result, fflags, tag_o
    );
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter  int WIDTH = 27,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count
);
    // Higher set bits overwrite lower ones, so the MSB-most one decides.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CW'(WIDTH - 1 - i);
        end
    end
endmodule

// File: rtl/fp_addsub_pipe.sv
// Pipelined IEEE-754 add/subtract: EA (align) -> AS (add) -> N (normalise) -> round/output.
// Fixed latency of three enabled edges, per-stage clear, sideband tag carried along.
module fp_addsub_pipe
    import fp_addsub_pipe_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] clear,
    output logic [2:0] stg_vld,
    fp_addsub_pipe_if.slave io
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int F    = MAN_W;
    localparam int MW   = F + 4;
    localparam int XW   = EXP_W + 2;
    localparam int SHW  = $clog2(F + 4);
    localparam int LZW  = $clog2(MW + 1);
    localparam int WIDE = 2 * F + 4;
    localparam logic [XW-1:0]  EMAX    = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]   QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(F-1){1'b0}}};
    localparam logic [W-2:0]   INF_MAG = {{EXP_W{1'b1}}, {F{1'b0}}};
    localparam logic [W-2:0]   MAX_MAG = {{(EXP_W-1){1'b1}}, 1'b0, {F{1'b1}}};

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        rm_e              rm;
        logic             spec;
        logic             spec_nv;
        logic [W-1:0]     spec_res;
    } ctl_t;

    typedef struct packed {
        ctl_t             ctl;
        logic             l_sign;
        logic             s_sign;
        logic [EXP_W-1:0] l_exp;
        logic [F:0]       l_man;
        logic [F+2:0]     s_al;
        logic             sticky;
    } ea_t;

    typedef struct packed {
        ctl_t             ctl;
        logic             sign;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [F+4:0]     sum;
    } as_t;

    typedef struct packed {
        ctl_t          ctl;
        logic          sign;
        logic          eff_sub;
        logic          zero;
        logic [XW-1:0] exp;
        logic [MW-1:0] man;
    } n_t;

    ea_t ea_d, ea_q;
    as_t as_d, as_q;
    n_t  n_d,  n_q;

    // ---------------- EA: unpack, classify, swap, align ----------------
    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b, eff_a, eff_b, diff;
    logic [F-1:0]     frac_a, frac_b;
    logic             nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, swap;
    logic [F:0]       man_a, man_b, s_man;
    logic [SHW-1:0]   shamt;
    logic [WIDE-1:0]  wide;

    assign sign_a = io.num1[W-1];
    assign sign_b = io.num2[W-1] ^ io.add_sub;
    assign exp_a  = io.num1[W-2:F];
    assign exp_b  = io.num2[W-2:F];
    assign frac_a = io.num1[F-1:0];
    assign frac_b = io.num2[F-1:0];
    assign nan_a  = (&exp_a) & (|frac_a);
    assign nan_b  = (&exp_b) & (|frac_b);
    assign snan_a = nan_a & ~frac_a[F-1];
    assign snan_b = nan_b & ~frac_b[F-1];
    assign inf_a  = (&exp_a) & ~(|frac_a);
    assign inf_b  = (&exp_b) & ~(|frac_b);
    // Subnormals share the exponent of the smallest normal and lack the hidden bit.
    assign eff_a  = (exp_a == '0) ? EXP_W'(1) : exp_a;
    assign eff_b  = (exp_b == '0) ? EXP_W'(1) : exp_b;
    assign man_a  = {exp_a != '0, frac_a};
    assign man_b  = {exp_b != '0, frac_b};
    assign swap   = io.num2[W-2:0] > io.num1[W-2:0];
    assign s_man  = swap ? man_a : man_b;
    assign diff   = swap ? (eff_b - eff_a) : (eff_a - eff_b);
    assign shamt  = (diff > EXP_W'(F + 3)) ? SHW'(F + 3) : SHW'(diff);
    assign wide   = {s_man, {(F+3){1'b0}}} >> shamt;

    always_comb begin
        ea_d              = '0;
        ea_d.ctl.vld      = io.valid_i;
        ea_d.ctl.tag      = io.tag_i;
        ea_d.ctl.rm       = decode_rm(io.rm);
        ea_d.ctl.spec     = nan_a | nan_b | inf_a | inf_b;
        ea_d.ctl.spec_nv  = snan_a | snan_b | (inf_a & inf_b & (sign_a != sign_b));
        if (nan_a | nan_b | (inf_a & inf_b & (sign_a != sign_b))) ea_d.ctl.spec_res = QNAN;
        else if (inf_a)                                            ea_d.ctl.spec_res = {sign_a, INF_MAG};
        else                                                       ea_d.ctl.spec_res = {sign_b, INF_MAG};
        ea_d.l_sign = swap ? sign_b : sign_a;
        ea_d.s_sign = swap ? sign_a : sign_b;
        ea_d.l_exp  = swap ? eff_b : eff_a;
        ea_d.l_man  = swap ? man_b : man_a;
        ea_d.s_al   = wide[WIDE-1:F+1];
        ea_d.sticky = |wide[F:0];
    end

    // ---------------- AS: magnitude add/subtract ----------------
    logic [F+4:0] l_mag, s_mag;
    logic         eff_sub;

    assign l_mag   = {1'b0, ea_q.l_man, 3'b000};
    assign s_mag   = {1'b0, ea_q.s_al, ea_q.sticky};
    assign eff_sub = ea_q.l_sign ^ ea_q.s_sign;

    always_comb begin
        as_d         = '0;
        as_d.ctl     = ea_q.ctl;
        as_d.sign    = ea_q.l_sign;
        as_d.eff_sub = eff_sub;
        as_d.exp     = ea_q.l_exp;
        as_d.sum     = eff_sub ? (l_mag - s_mag) : (l_mag + s_mag);
    end

    // ---------------- N: normalise, clamp to subnormal ----------------
    logic [LZW-1:0] lz;
    logic [XW-1:0]  exp_x, room, shl;

    fp_lzc #(.WIDTH(MW)) u_lzc (
        .value (as_q.sum[MW-1:0]),
        .count (lz)
    );

    assign exp_x = {2'b00, as_q.exp};
    assign room  = exp_x - XW'(1);
    assign shl   = (XW'(lz) > room) ? room : XW'(lz);

    always_comb begin
        n_d         = '0;
        n_d.ctl     = as_q.ctl;
        n_d.sign    = as_q.sign;
        n_d.eff_sub = as_q.eff_sub;
        n_d.zero    = ~(|as_q.sum);
        if (as_q.sum[F+4]) begin
            n_d.man = {as_q.sum[F+4:2], as_q.sum[1] | as_q.sum[0]};
            n_d.exp = exp_x + XW'(1);
        end else begin
            n_d.man = as_q.sum[MW-1:0] << shl;
            n_d.exp = exp_x - shl;
        end
    end

    // ---------------- Round (combinational after N) ----------------
    logic          lsb, g, rs, inexact, round_up, rcarry, hid, ovf, to_inf;
    logic [F+1:0]  mr;
    logic [XW-1:0] exp_r;
    logic [F-1:0]  frac_r;
    logic [W-1:0]  res_d;
    fflags_t       flags_d;

    assign lsb     = n_q.man[3];
    assign g       = n_q.man[2];
    assign rs      = |n_q.man[1:0];
    assign inexact = g | rs;

    always_comb begin
        case (n_q.ctl.rm)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = inexact & n_q.sign;
            RM_RUP:  round_up = inexact & ~n_q.sign;
            RM_RMM:  round_up = g;
            default: round_up = g & (rs | lsb);
        endcase
    end

    // A carry out of the mantissa renormalises to 1.0 with the exponent bumped.
    assign mr     = {1'b0, n_q.man[MW-1:3]} + (F+2)'(round_up);
    assign rcarry = mr[F+1];
    assign hid    = rcarry | mr[F];
    assign exp_r  = n_q.exp + XW'(rcarry);
    assign frac_r = rcarry ? '0 : mr[F-1:0];
    assign ovf    = hid & (exp_r >= EMAX);
    assign to_inf = (n_q.ctl.rm == RM_RNE) || (n_q.ctl.rm == RM_RMM) ||
                    ((n_q.ctl.rm == RM_RDN) && n_q.sign) || ((n_q.ctl.rm == RM_RUP) && !n_q.sign);

    always_comb begin
        res_d   = '0;
        flags_d = '0;
        if (n_q.ctl.spec) begin
            res_d      = n_q.ctl.spec_res;
            flags_d.nv = n_q.ctl.spec_nv;
        end else if (n_q.zero) begin
            res_d[W-1] = n_q.eff_sub ? (n_q.ctl.rm == RM_RDN) : n_q.sign;
        end else if (ovf) begin
            res_d      = {n_q.sign, to_inf ? INF_MAG : MAX_MAG};
            flags_d.of = 1'b1;
            flags_d.nx = 1'b1;
        end else begin
            res_d      = {n_q.sign, hid ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}, frac_r};
            flags_d.uf = ~hid & inexact;
            flags_d.nx = inexact;
        end
    end

    // ---------------- Registers: rst > clear[k] > en > hold ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          ea_q <= '0;
        else if (clear[0]) ea_q <= '0;
        else if (en)       ea_q <= ea_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          as_q <= '0;
        else if (clear[1]) as_q <= '0;
        else if (en)       as_q <= as_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          n_q <= '0;
        else if (clear[2]) n_q <= '0;
        else if (en)       n_q <= n_d;
    end

    logic             vld_q;
    logic [W-1:0]     res_q;
    fflags_t          flags_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q   <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            tag_q   <= '0;
        end else if (en) begin
            vld_q <= n_q.ctl.vld;
            if (n_q.ctl.vld) begin
                res_q   <= res_d;
                flags_q <= flags_d;
                tag_q   <= n_q.ctl.tag;
            end
        end
    end

    assign io.valid_o = vld_q;
    assign io.result  = res_q;
    assign io.fflags  = flags_q;
    assign io.tag_o   = tag_q;
    assign stg_vld    = {n_q.ctl.vld, as_q.ctl.vld, ea_q.ctl.vld};

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: FP32 and FP16 builds, hand-computed expected values.
module tb_fp_addsub_pipe;
  import fp_addsub_pipe_pkg::*;

  localparam int TW = 8;
  localparam int QW = TW + 32 + 5;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] clear;
  logic [2:0] stg_vld32, stg_vld16;

  always #5 clk = ~clk;

  fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(TW)) bus32 ();
  fp_addsub_pipe_if #(.EXP_W(5), .MAN_W(10), .TAG_W(TW)) bus16 ();

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(TW)) u_dut32 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clear   (clear),
    .stg_vld (stg_vld32),
    .io      (bus32)
  );

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(TW)) u_dut16 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clear   (clear),
    .stg_vld (stg_vld16),
    .io      (bus16)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] exp16_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  // One clock; on an enabled edge every retiring op is compared in order.
  task automatic tick();
    logic          en_s;
    logic [QW-1:0] e;
    en_s = en;
    @(posedge clk);
    #1;
    if (en_s && bus32.valid_o) begin
      if (exp_q.size() == 0) check("unexp32", 64'(bus32.tag_o), 64'hdead);
      else begin
        e = exp_q.pop_front();
        check($sformatf("res32_t%0d", e[QW-1 -: TW]), 64'(bus32.result), 64'(e[36:5]));
        check($sformatf("flg32_t%0d", e[QW-1 -: TW]), 64'(bus32.fflags), 64'(e[4:0]));
        check($sformatf("tag32_t%0d", e[QW-1 -: TW]), 64'(bus32.tag_o), 64'(e[QW-1 -: TW]));
      end
    end
    if (en_s && bus16.valid_o) begin
      if (exp16_q.size() == 0) check("unexp16", 64'(bus16.tag_o), 64'hdead);
      else begin
        e = exp16_q.pop_front();
        check($sformatf("res16_t%0d", e[QW-1 -: TW]), 64'(bus16.result), 64'(e[36:5]));
        check($sformatf("flg16_t%0d", e[QW-1 -: TW]), 64'(bus16.fflags), 64'(e[4:0]));
        check($sformatf("tag16_t%0d", e[QW-1 -: TW]), 64'(bus16.tag_o), 64'(e[QW-1 -: TW]));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus32.valid_i = 1'b0;
    bus16.valid_i = 1'b0;
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [2:0] rmode, input logic [TW-1:0] tg,
                         input logic [31:0] res, input logic [4:0] fl, input bit keep);
    bus32.valid_i = 1'b1;
    bus32.num1    = a;
    bus32.num2    = b;
    bus32.add_sub = sub;
    bus32.rm      = rmode;
    bus32.tag_i   = tg;
    if (keep) exp_q.push_back({tg, res, fl});
    tick();
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic [2:0] rmode, input logic [TW-1:0] tg,
                         input logic [15:0] res, input logic [4:0] fl);
    bus16.valid_i = 1'b1;
    bus16.num1    = a;
    bus16.num2    = b;
    bus16.add_sub = sub;
    bus16.rm      = rmode;
    bus16.tag_i   = tg;
    exp16_q.push_back({tg, 16'h0000, res, fl});
    tick();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
    check("drain32_left", 64'(exp_q.size()), 64'd0);
    check("drain16_left", 64'(exp16_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b0;
    en    = 1'b1;
    clear = 3'b000;
    bus32.valid_i = 1'b0; bus32.add_sub = 1'b0; bus32.num1 = '0; bus32.num2 = '0;
    bus32.rm = 3'b000; bus32.tag_i = '0;
    bus16.valid_i = 1'b0; bus16.add_sub = 1'b0; bus16.num1 = '0; bus16.num2 = '0;
    bus16.rm = 3'b000; bus16.tag_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", 64'(bus32.valid_o), 64'd0);
    check("rst_result",  64'(bus32.result),  64'd0);
    check("rst_fflags",  64'(bus32.fflags),  64'd0);
    check("rst_tag_o",   64'(bus32.tag_o),   64'd0);
    check("rst_stg_vld", 64'(stg_vld32),     64'd0);
    rst = 1'b1;
    tick();

    // Latency: accepted on one edge, visible after the third following edge.
    issue32(32'h3F800000, 32'h40000000, 1'b0, RM_RNE, 8'd1, 32'h40400000, 5'b00000, 1'b1);
    idle();
    check("lat_stg_ea", 64'(stg_vld32), 64'b001);
    tick(); check("lat_c1", 64'(bus32.valid_o), 64'd0);
    tick(); check("lat_c2", 64'(bus32.valid_o), 64'd0);
    tick(); check("lat_c3", 64'(bus32.valid_o), 64'd1);
    tick(); check("pulse",  64'(bus32.valid_o), 64'd0);

    // Back-to-back directed vectors.
    issue32(32'h3F800000, 32'h3F800000, 1'b1, RM_RNE, 8'd2,  32'h00000000, 5'b00000, 1'b1);
    issue32(32'h3F800000, 32'h3F800000, 1'b1, RM_RDN, 8'd3,  32'h80000000, 5'b00000, 1'b1);
    issue32(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RM_RNE, 8'd4,  32'h7F800000, FFLAG_OF | FFLAG_NX, 1'b1);
    issue32(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RM_RTZ, 8'd5,  32'h7F7FFFFF, FFLAG_OF | FFLAG_NX, 1'b1);
    issue32(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RM_RDN, 8'd6,  32'h7F7FFFFF, FFLAG_OF | FFLAG_NX, 1'b1);
    issue32(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, RM_RUP, 8'd7,  32'hFF7FFFFF, FFLAG_OF | FFLAG_NX, 1'b1);
    issue32(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, RM_RDN, 8'd8,  32'hFF800000, FFLAG_OF | FFLAG_NX, 1'b1);
    issue32(32'h7F800000, 32'h7F800000, 1'b1, RM_RNE, 8'd9,  32'h7FC00000, FFLAG_NV, 1'b1);
    issue32(32'h7F800001, 32'h3F800000, 1'b0, RM_RNE, 8'd10, 32'h7FC00000, FFLAG_NV, 1'b1);
    issue32(32'h00800000, 32'h00000001, 1'b1, RM_RNE, 8'd11, 32'h007FFFFF, 5'b00000, 1'b1);
    issue32(32'h3F800000, 32'h33800000, 1'b0, RM_RNE, 8'd12, 32'h3F800000, FFLAG_NX, 1'b1);
    issue32(32'h3F800000, 32'h33800000, 1'b0, RM_RMM, 8'd13, 32'h3F800001, FFLAG_NX, 1'b1);
    issue32(32'h3F800000, 32'h33000000, 1'b1, RM_RNE, 8'd14, 32'h3F800000, FFLAG_NX, 1'b1);
    issue32(32'h3F800000, 32'h33000000, 1'b1, RM_RTZ, 8'd15, 32'h3F7FFFFF, FFLAG_NX, 1'b1);
    issue32(32'h3F800001, 32'h3F800000, 1'b1, RM_RNE, 8'd16, 32'h34000000, 5'b00000, 1'b1);
    issue32(32'h80000000, 32'h80000000, 1'b0, RM_RUP, 8'd17, 32'h80000000, 5'b00000, 1'b1);
    issue32(32'h00000000, 32'h80000000, 1'b0, RM_RNE, 8'd18, 32'h00000000, 5'b00000, 1'b1);
    issue32(32'h00000000, 32'h80000000, 1'b0, RM_RDN, 8'd19, 32'h80000000, 5'b00000, 1'b1);
    issue32(32'h7F800000, 32'h3F800000, 1'b0, RM_RNE, 8'd20, 32'h7F800000, 5'b00000, 1'b1);
    issue32(32'h3F800000, 32'h33800000, 1'b0, 3'b111, 8'd21, 32'h3F800000, FFLAG_NX, 1'b1);
    issue32(32'h7FC00000, 32'h3F800000, 1'b0, RM_RNE, 8'd22, 32'h7FC00000, 5'b00000, 1'b1);
    issue32(32'hFF800000, 32'h3F800000, 1'b1, RM_RNE, 8'd23, 32'hFF800000, 5'b00000, 1'b1);
    idle();
    drain(8);

    // Three back-to-back ops; clear[1] drops the middle one, then a two-cycle stall.
    issue32(32'h3F800000, 32'h3F800000, 1'b0, RM_RNE, 8'd40, 32'h40000000, 5'b00000, 1'b1);
    issue32(32'h40000000, 32'h40000000, 1'b0, RM_RNE, 8'd41, 32'h40800000, 5'b00000, 1'b0);
    clear = 3'b010;
    issue32(32'h40400000, 32'h3F800000, 1'b1, RM_RNE, 8'd42, 32'h40000000, 5'b00000, 1'b1);
    clear = 3'b000;
    idle();
    check("clr1_stg", 64'(stg_vld32), 64'b101);
    en = 1'b0;
    tick(); check("stall1_stg", 64'(stg_vld32), 64'b101); check("stall1_vo", 64'(bus32.valid_o), 64'd0);
    tick(); check("stall2_stg", 64'(stg_vld32), 64'b101); check("stall2_vo", 64'(bus32.valid_o), 64'd0);
    en = 1'b1;
    drain(6);

    // A clear while stalled still takes effect.
    issue32(32'h3F800000, 32'h3F800000, 1'b0, RM_RNE, 8'd50, 32'h40000000, 5'b00000, 1'b0);
    idle();
    en    = 1'b0;
    clear = 3'b001;
    tick();
    clear = 3'b000;
    check("clr0_hold_stg", 64'(stg_vld32), 64'd0);
    en = 1'b1;
    drain(5);

    // FP16 build.
    issue16(16'h3C00, 16'h3C00, 1'b0, RM_RNE, 8'd60, 16'h4000, 5'b00000);
    issue16(16'h7BFF, 16'h7BFF, 1'b0, RM_RUP, 8'd61, 16'h7C00, FFLAG_OF | FFLAG_NX);
    idle();
    drain(6);

    // Asynchronous reset with an op in flight.
    issue32(32'h3F800000, 32'h3F800000, 1'b0, RM_RNE, 8'd70, 32'h40000000, 5'b00000, 1'b0);
    idle();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_stg",  64'(stg_vld32),     64'd0);
    check("rstmid_vo",   64'(bus32.valid_o), 64'd0);
    check("rstmid_res",  64'(bus32.result),  64'd0);
    check("rstmid_tag",  64'(bus32.tag_o),   64'd0);
    @(negedge clk);
    rst = 1'b1;
    drain(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
